pwm_capture: RTL and testbench

//  Receive end of the PWM link: measures an incoming PWM waveform and recovers its duty cycle
//  as an R-bit code, the inverse of the duty->PWM generator (duty ~ ciclo/2^R).

---
 rtl/pwm_capture.sv | 160 ++++++++++++++++
 tb/tb_pwm_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of pwm_in and recovers the duty code
// floor(high * 2^R / period) with a restoring divider producing one quotient bit per clock.
module pwm_capture #(
    parameter int unsigned R = 8,
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [R-1:0] duty,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] period_cnt,
    output logic         duty_valid,
    output logic         err_short,
    output logic         timeout
);

    localparam int unsigned CW = $clog2(R + 1);
    localparam logic [W-1:0] CntMax = '1;
    localparam logic [CW-1:0] LastStep = CW'(R);

    typedef enum logic [1:0] {StIdle, StMeasure, StDivide, StTimeout} state_e;

    state_e state_q, state_d;

    logic          sync1_q, sync2_q, sync_dly_q;
    logic          rise;
    logic [W-1:0]  per_c_q, hi_c_q;
    logic [W-1:0]  p_q, p_d, h_q, h_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [R-1:0]  quo_q, quo_d;
    logic [CW-1:0] step_q, step_d;
    logic [R-1:0]  duty_d;
    logic [W-1:0]  high_cnt_d, period_cnt_d;
    logic          duty_valid_d, err_short_d, timeout_d;

    logic [W:0]    rem_shift;
    logic [W-1:0]  rem_sub;
    logic          take;

    assign rise = sync2_q & ~sync_dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync_dly_q <= 1'b0;
            per_c_q    <= '0;
            hi_c_q     <= '0;
        end else begin
            sync1_q    <= pwm_in;
            sync2_q    <= sync1_q;
            sync_dly_q <= sync2_q;
            // The rise cycle itself is cycle 1 of the new period (and is high).
            if (rise) begin
                per_c_q <= W'(1);
                hi_c_q  <= W'(1);
            end else begin
                if (per_c_q != CntMax) per_c_q <= per_c_q + W'(1);
                if (sync2_q && hi_c_q != CntMax) hi_c_q <= hi_c_q + W'(1);
            end
        end
    end

    // Remainder stays below P, so only the shifted value needs the extra bit.
    assign rem_shift = {rem_q, 1'b0};
    assign take      = rem_shift >= {1'b0, p_q};
    assign rem_sub   = rem_shift[W-1:0] - p_q;

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        h_d          = h_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        step_d       = step_q;
        duty_d       = duty;
        high_cnt_d   = high_cnt;
        period_cnt_d = period_cnt;
        duty_valid_d = 1'b0;
        err_short_d  = 1'b0;
        timeout_d    = timeout;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    timeout_d = 1'b0;
                    state_d   = StMeasure;
                end
            end
            StMeasure: begin
                if (rise) begin
                    p_d     = per_c_q;
                    h_d     = hi_c_q;
                    rem_d   = hi_c_q;
                    quo_d   = '0;
                    step_d  = '0;
                    state_d = StDivide;
                end else if (per_c_q == CntMax) begin
                    state_d = StTimeout;
                end
            end
            StDivide: begin
                if (rise) begin
                    err_short_d = 1'b1;
                    state_d     = StMeasure;
                end else if (step_q == LastStep) begin
                    duty_d       = quo_q;
                    high_cnt_d   = h_q;
                    period_cnt_d = p_q;
                    duty_valid_d = 1'b1;
                    state_d      = StMeasure;
                end else begin
                    rem_d  = take ? rem_sub : rem_shift[W-1:0];
                    quo_d  = {quo_q[R-2:0], take};
                    step_d = step_q + CW'(1);
                end
            end
            StTimeout: begin
                timeout_d    = 1'b1;
                duty_d       = sync2_q ? '1 : '0;
                high_cnt_d   = sync2_q ? CntMax : '0;
                period_cnt_d = CntMax;
                duty_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            p_q        <= '0;
            h_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            step_q     <= '0;
            duty       <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            duty_valid <= 1'b0;
            err_short  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            h_q        <= h_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            step_q     <= step_d;
            duty       <= duty_d;
            high_cnt   <= high_cnt_d;
            period_cnt <= period_cnt_d;
            duty_valid <= duty_valid_d;
            err_short  <= err_short_d;
            timeout    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (R=8, W=16): table of square waves with hand-computed
// duty codes, plus sequences for latency, short periods, timeout and async reset.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwm_in = 1'b0;
    logic [7:0]  duty;
    logic [15:0] high_cnt, period_cnt;
    logic        duty_valid, err_short, timeout;

    int n_cmp = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err = 0;
    int both_seen = 0;

    pwm_capture #(.R(8), .W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .duty_valid (duty_valid),
        .err_short  (err_short),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (duty_valid) n_valid++;
            if (err_short) n_err++;
            if (duty_valid && err_short) both_seen++;
        end
    end

    typedef struct {
        int unsigned p;
        int unsigned h;
        int unsigned exp_duty;
    } vec_t;

    vec_t vecs[9];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_wave(input int p, input int h, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            tick(h);
            pwm_in = 1'b0;
            tick(p - h);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        pwm_in = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(3);
    endtask

    initial begin
        int v0, e0, lat;

        vecs[0] = '{p: 100,  h: 50,  exp_duty: 128};
        vecs[1] = '{p: 10,   h: 3,   exp_duty: 76};
        vecs[2] = '{p: 256,  h: 1,   exp_duty: 1};
        vecs[3] = '{p: 256,  h: 128, exp_duty: 128};
        vecs[4] = '{p: 256,  h: 255, exp_duty: 255};
        vecs[5] = '{p: 100,  h: 25,  exp_duty: 64};
        vecs[6] = '{p: 13,   h: 1,   exp_duty: 19};
        vecs[7] = '{p: 1000, h: 999, exp_duty: 255};
        vecs[8] = '{p: 37,   h: 20,  exp_duty: 138};

        // Reset state
        tick(2);
        check("reset_duty", 32'(duty), 0);
        check("reset_high", 32'(high_cnt), 0);
        check("reset_period", 32'(period_cnt), 0);
        check("reset_flags", {29'd0, duty_valid, err_short, timeout}, 0);
        reset = 1'b0;
        tick(5);

        // Pin edge -> rise acted on at 3rd edge, duty_valid 9 edges later
        pwm_in = 1'b1;
        tick(50);
        pwm_in = 1'b0;
        tick(50);
        pwm_in = 1'b1;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (duty_valid) begin
                lat = k;
                break;
            end
        end
        check("latency_edges", 32'(lat), 12);
        check("latency_duty", 32'(duty), 128);

        // Table of waves: 4 periods plus a trailing rise; 4 results per vector
        do_reset();
        for (int i = 0; i < 9; i++) begin
            v0 = n_valid;
            e0 = n_err;
            run_wave(int'(vecs[i].p), int'(vecs[i].h), 4);
            pwm_in = 1'b1;
            tick(14);
            check($sformatf("vec%0d_duty", i), 32'(duty), vecs[i].exp_duty);
            check($sformatf("vec%0d_high", i), 32'(high_cnt), vecs[i].h);
            check($sformatf("vec%0d_period", i), 32'(period_cnt), vecs[i].p);
            check($sformatf("vec%0d_nvalid", i), 32'(n_valid - v0), 4);
            check($sformatf("vec%0d_nerr", i), 32'(n_err - e0), 0);
        end

        // P=6: each latched period is aborted by the next rise, which starts a fresh
        // period that gets latched again, so errors fall on rises 3, 5 and 7.
        do_reset();
        v0 = n_valid;
        e0 = n_err;
        run_wave(6, 3, 8);
        check("short_nerr", 32'(n_err - e0), 3);
        check("short_nvalid", 32'(n_valid - v0), 0);
        check("short_duty", 32'(duty), 0);
        check("short_period", 32'(period_cnt), 0);

        // Timeout with pin held low
        do_reset();
        run_wave(100, 50, 3);
        check("pre_to_duty", 32'(duty), 128);
        v0 = n_valid;
        tick(70000);
        check("to_flag", 32'(timeout), 1);
        check("to_duty", 32'(duty), 0);
        check("to_high", 32'(high_cnt), 0);
        check("to_period", 32'(period_cnt), 65535);
        check("to_nvalid", 32'(n_valid - v0), 1);
        pwm_in = 1'b1;
        tick(5);
        check("to_clear", 32'(timeout), 0);
        tick(20);
        pwm_in = 1'b0;
        tick(75);
        pwm_in = 1'b1;
        tick(14);
        check("after_to_duty", 32'(duty), 64);
        check("after_to_high", 32'(high_cnt), 25);
        check("after_to_period", 32'(period_cnt), 100);

        // Async reset while a divide is in flight
        tick(11);
        pwm_in = 1'b0;
        tick(75);
        pwm_in = 1'b1;
        tick(5);
        reset = 1'b1;
        #1;
        check("rst_mid_duty", 32'(duty), 0);
        check("rst_mid_high", 32'(high_cnt), 0);
        check("rst_mid_period", 32'(period_cnt), 0);
        check("rst_mid_flags", {29'd0, duty_valid, err_short, timeout}, 0);
        tick(2);
        reset = 1'b0;
        v0 = n_valid;
        tick(20);
        pwm_in = 1'b0;
        tick(80);
        pwm_in = 1'b1;
        tick(11);
        check("post_rst_nvalid0", 32'(n_valid - v0), 0);
        check("post_rst_duty0", 32'(duty), 0);
        tick(2);
        check("post_rst_nvalid1", 32'(n_valid - v0), 1);

        check("valid_err_overlap", 32'(both_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
